// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: two-flop synchronizer, per-bit debounce counter,
// registered stable level plus one-cycle rise/fall strobes for each bit.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Each bit counts only while the synchronized level disagrees with the
  // accepted one; any agreement clears the count, so counters never wrap.
  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_stable  = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random bounce, checked
// every cycle against a sample-window model of the debounce rule.
module tb_switch_debouncer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable, rise_pulse, fall_pulse;

  int n_vec = 0;
  int n_err = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  // Reference: hist[n] is the level sampled at edge n (0 while in reset).
  // A bit flips at edge n when the D samples hist[n-1-D..n-2] all differ
  // from the currently accepted level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_rise   = '0;
  logic [W-1:0] m_fall   = '0;

  always @(posedge clk) begin
    int n;
    logic [W-1:0] s;
    logic ok;
    hist.push_back(reset_n ? sw_raw : '0);
    n = hist.size() - 1;
    m_rise = '0;
    m_fall = '0;
    if (!reset_n) begin
      m_stable = '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        ok = (n - 1 - D >= 0);
        for (int j = 2; j <= D + 1 && ok; j++) begin
          s = hist[n - j];
          if (s[b] == m_stable[b]) ok = 1'b0;
        end
        if (ok) begin
          m_stable[b] = ~m_stable[b];
          m_rise[b]   = m_stable[b];
          m_fall[b]   = ~m_stable[b];
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %02h, want %02h", tag, $time, obs, exp);
    end
  endtask

  // Compare on the falling edge, then drive the next input/reset values.
  task automatic cyc(input logic [W-1:0] v, input logic rn);
    @(negedge clk);
    check_val("sw_stable", sw_stable, m_stable);
    check_val("rise_pulse", rise_pulse, m_rise);
    check_val("fall_pulse", fall_pulse, m_fall);
    sw_raw  = v;
    reset_n = rn;
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(v, 1'b1);
  endtask

  task automatic assert_reset_now();
    #1;
    check_val("async_rst_stable", sw_stable, '0);
    check_val("async_rst_rise", rise_pulse, '0);
    check_val("async_rst_fall", fall_pulse, '0);
  endtask

  initial begin
    logic [W-1:0] bounce [6];
    bounce = '{8'h81, 8'h01, 8'h81, 8'h81, 8'h01, 8'h81};

    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0);
    hold(8'h00, 4);

    // Clean rise on bit 0
    hold(8'h01, 10);

    // Glitch of D-1 cycles on bit 3, then one of exactly D cycles
    hold(8'h09, 3);
    hold(8'h01, 10);
    hold(8'h09, 4);
    hold(8'h01, 12);

    // Bounce on bit 7 before settling high
    for (int i = 0; i < 6; i++) hold(bounce[i], 1);
    hold(8'h81, 10);

    // All bits moving on one edge
    hold(8'h0F, 10);
    hold(8'hF0, 10);

    // Reset in the middle of a count
    hold(8'h00, 10);
    hold(8'hFF, 2);
    cyc(8'hFF, 1'b0);
    assert_reset_now();
    cyc(8'hFF, 1'b0);
    cyc(8'hFF, 1'b0);
    hold(8'hFF, 10);

    // Switches already high when reset releases
    cyc(8'h81, 1'b0);
    assert_reset_now();
    cyc(8'h81, 1'b0);
    cyc(8'h81, 1'b0);
    hold(8'h81, 10);

    // Random levels with hold lengths straddling the debounce window
    for (int i = 0; i < 250; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      hold(v, $urandom_range(1, 2 * D));
    end
    hold(8'h00, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
